// File: rtl/sap_controller_if.sv
// Control bus between the SAP-1 sequencer and its datapath: IR opcode in,
// ring state, register load/enable strobes and halt flag out.
interface sap_controller_if;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic       cp;
  logic       low_ep;
  logic       low_lm;
  logic       low_ce;
  logic       low_li;
  logic       low_ei;
  logic       low_la;
  logic       low_ea;
  logic       su;
  logic       low_eu;
  logic       low_lb;
  logic       low_lo;
  logic       halted;

  modport master (
    input  opcode,
    output tstate, cp, low_ep, low_lm, low_ce, low_li, low_ei,
           low_la, low_ea, su, low_eu, low_lb, low_lo, halted
  );

  modport slave (
    output opcode,
    input  tstate, cp, low_ep, low_lm, low_ce, low_li, low_ei,
           low_la, low_ea, su, low_eu, low_lb, low_lo, halted
  );
endinterface

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring advanced on the falling clock
// edge, with a combinational microcode decode of ring state and IR opcode.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input logic              clk,
  input logic              low_async_reset,
  sap_controller_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state;
  logic     halted_q;

  // Falling-edge advance gives the strobes half a cycle to settle before
  // the datapath captures on the rising edge.
  always_ff @(negedge clk or negedge low_async_reset) begin
    if (!low_async_reset) begin
      state    <= T1;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      case (state)
        T1: state <= T2;
        T2: state <= T3;
        T3: state <= T4;
        T4: begin
          if (bus.opcode == OP_HLT) halted_q <= 1'b1;
          else                      state    <= T5;
        end
        T5: state <= T6;
        T6: state <= T1;
        default: state <= T1;
      endcase
    end
  end

  logic cp, low_ep, low_lm, low_ce, low_li, low_ei;
  logic low_la, low_ea, su, low_eu, low_lb, low_lo;

  // Reset is folded in directly so an asserted reset kills every strobe
  // without waiting for a clock edge.
  always_comb begin
    cp     = 1'b0;
    low_ep = 1'b1;
    low_lm = 1'b1;
    low_ce = 1'b1;
    low_li = 1'b1;
    low_ei = 1'b1;
    low_la = 1'b1;
    low_ea = 1'b1;
    su     = 1'b0;
    low_eu = 1'b1;
    low_lb = 1'b1;
    low_lo = 1'b1;
    if (low_async_reset && !halted_q) begin
      case (state)
        T1: begin
          low_ep = 1'b0;
          low_lm = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          low_ce = 1'b0;
          low_li = 1'b0;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            low_ei = 1'b0;
            low_lm = 1'b0;
          end else if (bus.opcode == OP_OUT) begin
            low_ea = 1'b0;
            low_lo = 1'b0;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            low_ce = 1'b0;
            low_la = 1'b0;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            low_ce = 1'b0;
            low_lb = 1'b0;
            su     = (bus.opcode == OP_SUB);
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            low_eu = 1'b0;
            low_la = 1'b0;
            su     = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tstate = state;
  assign bus.halted = halted_q;
  assign bus.cp     = cp;
  assign bus.low_ep = low_ep;
  assign bus.low_lm = low_lm;
  assign bus.low_ce = low_ce;
  assign bus.low_li = low_li;
  assign bus.low_ei = low_ei;
  assign bus.low_la = low_la;
  assign bus.low_ea = low_ea;
  assign bus.su     = su;
  assign bus.low_eu = low_eu;
  assign bus.low_lb = low_lb;
  assign bus.low_lo = low_lo;

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: directed instruction programs plus random opcodes,
// compared every cycle against a step-counter/microcode-table reference model.
module tb_sap_controller;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  // Clock / reset
  logic clk = 1'b0;
  logic low_async_reset = 1'b0;
  always #5 clk = ~clk;

  sap_controller_if bus ();

  sap_controller dut (
    .clk             (clk),
    .low_async_reset (low_async_reset),
    .bus             (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: step number 1..6 and a halt flag
  int          m_step  = 1;
  bit          m_halt  = 1'b0;
  logic [3:0]  prog_q[$];
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h step=%0d op=%0h t=%0t", tag, got, exp, m_step, bus.opcode, $time);
    end
  endtask

  // Bit order: cp ep lm ce li ei la ea su eu lb lo
  function automatic logic [11:0] exp_ctrl(int step, logic [3:0] op, bit halt, bit rst_n);
    logic cp = 1'b0, su = 1'b0;
    logic ep = 1'b1, lm = 1'b1, ce = 1'b1, li = 1'b1, ei = 1'b1;
    logic la = 1'b1, ea = 1'b1, eu = 1'b1, lb = 1'b1, lo = 1'b1;
    if (rst_n && !halt) begin
      if (step == 1) begin ep = 1'b0; lm = 1'b0; end
      if (step == 2) cp = 1'b1;
      if (step == 3) begin ce = 1'b0; li = 1'b0; end
      if (step == 4 && (op == LDA || op == ADD || op == SUB)) begin ei = 1'b0; lm = 1'b0; end
      if (step == 4 && op == OUT) begin ea = 1'b0; lo = 1'b0; end
      if (step == 5 && op == LDA) begin ce = 1'b0; la = 1'b0; end
      if (step == 5 && (op == ADD || op == SUB)) begin ce = 1'b0; lb = 1'b0; su = (op == SUB); end
      if (step == 6 && (op == ADD || op == SUB)) begin eu = 1'b0; la = 1'b0; su = (op == SUB); end
    end
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {bus.cp, bus.low_ep, bus.low_lm, bus.low_ce, bus.low_li, bus.low_ei,
            bus.low_la, bus.low_ea, bus.su, bus.low_eu, bus.low_lb, bus.low_lo};
  endfunction

  task automatic check_all(input string tag);
    int drivers;
    drivers = int'(!bus.low_ep) + int'(!bus.low_ce) + int'(!bus.low_ei)
            + int'(!bus.low_ea) + int'(!bus.low_eu);
    exp_q.push_back(exp_ctrl(m_step, bus.opcode, m_halt, low_async_reset));
    check({tag, "_tstate"}, 32'(bus.tstate), 32'(6'b000001 << (m_step - 1)));
    check({tag, "_halted"}, 32'(bus.halted), 32'(m_halt));
    check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_q.pop_front()));
    check({tag, "_one_driver"}, 32'(drivers <= 1), 32'd1);
  endtask

  // Driver: one falling edge, model update, check, then next opcode.
  task automatic cycle(input string tag);
    @(negedge clk);
    if (low_async_reset && !m_halt) begin
      if (m_step == 4 && bus.opcode == HLT) m_halt = 1'b1;
      else                                  m_step = (m_step % 6) + 1;
    end
    #2;
    check_all(tag);
    if (m_step == 1) bus.opcode = 4'($urandom_range(0, 15));
    if (m_step == 2) begin
      if (prog_q.size() > 0) bus.opcode = prog_q.pop_front();
      else if ($urandom_range(0, 3) == 0) bus.opcode = 4'b0101;
      else bus.opcode = 4'($urandom_range(0, 14));
    end
  endtask

  task automatic apply_reset(input int hold_cycles, input string tag);
    #1;
    low_async_reset = 1'b0;
    m_step = 1;
    m_halt = 1'b0;
    #1;
    check_all({tag, "_assert"});
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      #2;
      check_all({tag, "_hold"});
    end
    low_async_reset = 1'b1;
    #1;
    check_all({tag, "_release"});
  endtask

  initial begin
    bus.opcode = 4'b0000;

    // Reset held from time zero across 3 clocks, then released
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check_all("reset_hold");
    end
    low_async_reset = 1'b1;
    #1;
    check_all("reset_release");

    // Directed program ending in HLT, then 20 more halted cycles
    prog_q = {LDA, ADD, SUB, OUT, HLT};
    for (int i = 0; i < 48; i++) cycle("prog");
    check("halt_reached", 32'(bus.halted), 32'd1);
    check("halt_frozen_t4", 32'(bus.tstate), 32'h08);
    apply_reset(1, "halt_reset");

    // Reset asserted in T5 of ADD
    prog_q = {ADD};
    for (int i = 0; i < 12 && m_step != 5; i++) cycle("to_t5");
    check("reached_add_t5", 32'(m_step), 32'd5);
    check("add_t5_lb_low", 32'(bus.low_lb), 32'd0);
    apply_reset(0, "mid_reset");
    check("mid_reset_lb", 32'(bus.low_lb), 32'd1);

    // Random opcodes, including undefined ones
    for (int i = 0; i < 200; i++) cycle("rand");

    // Undefined opcode 0101 runs as a nop instruction
    prog_q = {4'b0101, LDA};
    for (int i = 0; i < 12; i++) cycle("undef");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Control sequencer for the SAP-1 datapath: a 6-state one-hot ring counter (T1..T6) plus a microcode decoder.
- Drives the active-low load and tristate output enables of the 4-bit/8-bit bus registers (PC, MAR, RAM, IR, A, B, ALU, OUT).
- Guarantees at most one bus driver per T-state.
- Consumes the IR opcode nibble; halts on HLT.

Parameters:
OP_LDA, 4'b0000, opcode for load accumulator
OP_ADD, 4'b0001, opcode for add memory to A
OP_SUB, 4'b0010, opcode for subtract memory from A
OP_OUT, 4'b1110, opcode for A to output register
OP_HLT, 4'b1111, opcode for halt

Ports:
clk  input  1  system clock; datapath registers capture on posedge
low_async_reset  input  1  asynchronous reset, active-low
opcode  input  4  upper nibble of IR, valid from T4
tstate  output  6  one-hot ring state, bit0=T1 .. bit5=T6
cp  output  1  PC increment, active-high
low_ep  output  1  PC output enable, active-low
low_lm  output  1  MAR load, active-low
low_ce  output  1  RAM output enable, active-low
low_li  output  1  IR load, active-low
low_ei  output  1  IR address-nibble output enable, active-low
low_la  output  1  A load, active-low
low_ea  output  1  A output enable, active-low
su  output  1  ALU subtract select, active-high
low_eu  output  1  ALU output enable, active-low
low_lb  output  1  B load, active-low
low_lo  output  1  OUT register load, active-low
halted  output  1  high once HLT is decoded

Behaviour:
- Reset (low_async_reset=0, asynchronous):
  - tstate=6'b000001 and halted=0.
  - While reset is held, all controls are forced inactive: cp=0, su=0, all low_* =1.
- State advance: on negedge clk, so controls are stable a half-cycle before the posedge capture.
  - T1->T2->...->T6->T1.
  - No advance while halted=1.
- Controls: combinational decode of tstate and opcode. Any signal not listed for a T-state is inactive.
- Fetch (all opcodes):
  - T1: low_ep=0, low_lm=0
  - T2: cp=1
  - T3: low_ce=0, low_li=0
- LDA:
  - T4: low_ei=0, low_lm=0
  - T5: low_ce=0, low_la=0
  - T6: nop
- ADD:
  - T4: low_ei=0, low_lm=0
  - T5: low_ce=0, low_lb=0
  - T6: low_eu=0, low_la=0, su=0
- SUB: same as ADD, plus su=1 throughout T5 and T6.
- OUT:
  - T4: low_ea=0, low_lo=0
  - T5, T6: nop
- HLT:
  - On the negedge that would leave T4 with opcode==OP_HLT, halted is set to 1 and tstate stays at T4.
  - While halted, all controls are inactive.
  - Only reset clears halt.
- Undefined opcodes: T4–T6 are nops; the sequence continues to T1.
- Opcode is ignored during T1–T3, so a stale IR value has no effect.
- Invariant: at most one of low_ep, low_ce, low_ei, low_ea, low_eu is 0 in any state, including during reset and halt.
- Instruction latency: exactly 6 clk cycles per non-HLT instruction.
- Reset mid-instruction: immediate return to T1 and inactive controls. First T1 decode appears after reset deasserts, with no partial-instruction side effects.
- tstate is always exactly one-hot.

Test Plan:
- Reset: hold low_async_reset=0 across 3 clocks -> tstate=000001, halted=0, all low_*=1, cp=0, su=0. Release -> low_ep=0 and low_lm=0 before the next posedge.
- LDA: opcode=0000 over 6 cycles -> T1 ep/lm, T2 cp, T3 ce/li, T4 ei/lm, T5 ce/la, T6 all inactive. tstate returns to 000001 after 6 negedges.
- ADD then SUB: opcode=0001 -> T6 low_eu=0, low_la=0, su=0. Next instruction opcode=0010 -> su=1 in T5 and T6 only.
- OUT then HLT: opcode=1110 -> T4 low_ea=0, low_lo=0. Next opcode=1111 -> tstate frozen at 001000, halted=1, controls inactive for 20 cycles. Reset -> halted=0, tstate=000001.
- Mid-cycle reset: assert reset in T5 of ADD -> low_lb returns to 1 immediately (asynchronously) and tstate=000001.
- Bus-driver invariant and undefined opcode: random opcodes including 0101 over 200 cycles -> never more than one output-enable low. Opcode 0101 gives nop in T4–T6.
